// File: rtl/soc_bus_ctrl.sv
// soc_bus_ctrl: bridges the CPU native memory port to a BRAM and a GPIO target.
// Unmapped accesses and target timeouts complete with 32'hDEAD_BEEF and a sticky error.
module soc_bus_ctrl #(
    parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] BRAM_SIZE = 32'h0001_0000,
    parameter logic [31:0] GPIO_BASE = 32'h0200_0000,
    parameter logic [31:0] GPIO_SIZE = 32'h0000_1000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_mem_valid,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,

    output logic        bram_valid,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic        bram_ready,
    input  logic [31:0] bram_rdata,

    output logic        gpio_valid,
    output logic [31:0] gpio_addr,
    output logic [31:0] gpio_wdata,
    output logic [3:0]  gpio_wstrb,
    input  logic        gpio_ready,
    input  logic [31:0] gpio_rdata,

    output logic        bus_err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] BRAM_MASK = ~(BRAM_SIZE - 32'd1);
    localparam logic [31:0] GPIO_MASK = ~(GPIO_SIZE - 32'd1);
    localparam logic [7:0]  LAST_CNT  = 8'(TIMEOUT - 1);
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] req_addr;
    logic        sel_gpio;

    logic        bram_hit;
    logic        gpio_hit;
    logic        tgt_ready;
    logic [31:0] tgt_rdata;

    assign bram_hit = (cpu_mem_addr & BRAM_MASK) == BRAM_BASE;
    assign gpio_hit = (cpu_mem_addr & GPIO_MASK) == GPIO_BASE;

    // Only the target chosen at decode time can complete the access.
    assign tgt_ready = sel_gpio ? gpio_ready : bram_ready;
    assign tgt_rdata = sel_gpio ? gpio_rdata : bram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            req_addr      <= 32'd0;
            sel_gpio      <= 1'b0;
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= 32'd0;
            bram_valid    <= 1'b0;
            bram_addr     <= 32'd0;
            bram_wdata    <= 32'd0;
            bram_wstrb    <= 4'd0;
            gpio_valid    <= 1'b0;
            gpio_addr     <= 32'd0;
            gpio_wdata    <= 32'd0;
            gpio_wstrb    <= 4'd0;
            bus_err       <= 1'b0;
            err_addr      <= 32'd0;
        end else begin
            // A new error raised below overrides this clear.
            if (err_clr) begin
                bus_err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (cpu_mem_valid) begin
                        req_addr <= cpu_mem_addr;
                        cnt      <= 8'd0;
                        unique case (1'b1)
                            bram_hit: begin
                                sel_gpio   <= 1'b0;
                                bram_valid <= 1'b1;
                                bram_addr  <= cpu_mem_addr - BRAM_BASE;
                                bram_wdata <= cpu_mem_wdata;
                                bram_wstrb <= cpu_mem_wstrb;
                                state      <= ACCESS;
                            end
                            gpio_hit: begin
                                sel_gpio   <= 1'b1;
                                gpio_valid <= 1'b1;
                                gpio_addr  <= cpu_mem_addr - GPIO_BASE;
                                gpio_wdata <= cpu_mem_wdata;
                                gpio_wstrb <= cpu_mem_wstrb;
                                state      <= ACCESS;
                            end
                            default: begin
                                cpu_mem_rdata <= ERR_DATA;
                                cpu_mem_ready <= 1'b1;
                                bus_err       <= 1'b1;
                                err_addr      <= cpu_mem_addr;
                                state         <= RESP;
                            end
                        endcase
                    end
                end

                ACCESS: begin
                    if (tgt_ready) begin
                        cpu_mem_rdata <= tgt_rdata;
                        cpu_mem_ready <= 1'b1;
                        bram_valid    <= 1'b0;
                        gpio_valid    <= 1'b0;
                        state         <= RESP;
                    end else if (cnt == LAST_CNT) begin
                        cpu_mem_rdata <= ERR_DATA;
                        cpu_mem_ready <= 1'b1;
                        bram_valid    <= 1'b0;
                        gpio_valid    <= 1'b0;
                        bus_err       <= 1'b1;
                        err_addr      <= req_addr;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                RESP: begin
                    cpu_mem_ready <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// tb_soc_bus_ctrl: directed requests with a response scoreboard.
// Target models answer after a configurable number of valid cycles.
module tb_soc_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_valid;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        bram_valid;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic        bram_ready;
    logic [31:0] bram_rdata;
    logic        gpio_valid;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_wdata;
    logic [3:0]  gpio_wstrb;
    logic        gpio_ready;
    logic [31:0] gpio_rdata;
    logic        bus_err;
    logic [31:0] err_addr;
    logic        err_clr;

    soc_bus_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wstrb (cpu_mem_wstrb),
        .cpu_mem_ready (cpu_mem_ready),
        .cpu_mem_rdata (cpu_mem_rdata),
        .bram_valid    (bram_valid),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_wstrb    (bram_wstrb),
        .bram_ready    (bram_ready),
        .bram_rdata    (bram_rdata),
        .gpio_valid    (gpio_valid),
        .gpio_addr     (gpio_addr),
        .gpio_wdata    (gpio_wdata),
        .gpio_wstrb    (gpio_wstrb),
        .gpio_ready    (gpio_ready),
        .gpio_rdata    (gpio_rdata),
        .bus_err       (bus_err),
        .err_addr      (err_addr),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] eaddr;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    // target model configuration: ready in the Nth valid cycle, 0 = never
    int          b_at = 0;
    int          g_at = 0;
    logic        g_stuck = 1'b0;
    int          bcnt = 0;
    int          gcnt = 0;
    logic        b_seen, g_seen, g_unstable;
    int          g_cycles;
    logic [31:0] b_addr_cap, g_addr_cap, g_wdata_cap;
    logic [3:0]  g_wstrb_cap;
    logic        prev_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bram_valid) begin
            bcnt++;
            if (bcnt == 1) b_addr_cap = bram_addr;
            b_seen = 1'b1;
        end else begin
            bcnt = 0;
        end
        bram_ready = bram_valid && (b_at != 0) && (bcnt == b_at);

        if (gpio_valid) begin
            gcnt++;
            if (gcnt == 1) begin
                g_addr_cap  = gpio_addr;
                g_wdata_cap = gpio_wdata;
                g_wstrb_cap = gpio_wstrb;
            end else if (gpio_addr !== g_addr_cap ||
                         gpio_wdata !== g_wdata_cap ||
                         gpio_wstrb !== g_wstrb_cap) begin
                g_unstable = 1'b1;
            end
            g_seen   = 1'b1;
            g_cycles = gcnt;
        end else begin
            gcnt = 0;
        end
        gpio_ready = g_stuck || (gpio_valid && (g_at != 0) && (gcnt == g_at));
    end

    // monitor: every completion pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (cpu_mem_ready && prev_ready) begin
            chk("ready pulse width", 32'(prev_ready && cpu_mem_ready), 32'd0);
        end else if (cpu_mem_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, " rdata"}, cpu_mem_rdata, e.rdata);
                chk({e.name, " bus_err"}, 32'(bus_err), 32'(e.err));
                chk({e.name, " err_addr"}, err_addr, e.eaddr);
                chk({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
        prev_ready = cpu_mem_ready;
    end

    task automatic do_req(input string name, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic clr, input logic [31:0] x_rdata,
                          input logic x_err, input logic [31:0] x_eaddr,
                          input int x_lat);
        exp_t e;
        bit   done;
        @(negedge clk);
        b_seen        = 1'b0;
        g_seen        = 1'b0;
        g_unstable    = 1'b0;
        g_cycles      = 0;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = addr;
        cpu_mem_wdata = wdata;
        cpu_mem_wstrb = wstrb;
        err_clr       = clr;
        e.name  = name;
        e.rdata = x_rdata;
        e.err   = x_err;
        e.eaddr = x_eaddr;
        e.lat   = x_lat;
        e.t0    = cyc;
        exp_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (cpu_mem_ready) done = 1'b1;
        end
        cpu_mem_valid = 1'b0;
        if (!done) begin
            chk({name, " completion timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic clear_err(input logic [31:0] x_rdata);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr alone", 32'(bus_err), 32'd0);
        chk("rdata held", cpu_mem_rdata, x_rdata);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cpu_mem_ready"}, 32'(cpu_mem_ready), 32'd0);
        chk({tag, " cpu_mem_rdata"}, cpu_mem_rdata, 32'd0);
        chk({tag, " bram_valid"}, 32'(bram_valid), 32'd0);
        chk({tag, " gpio_valid"}, 32'(gpio_valid), 32'd0);
        chk({tag, " bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, " err_addr"}, err_addr, 32'd0);
        chk({tag, " bram_addr"}, bram_addr, 32'd0);
        chk({tag, " gpio_wdata"}, gpio_wdata, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        cpu_mem_valid = 1'b0;
        cpu_mem_addr  = 32'd0;
        cpu_mem_wdata = 32'd0;
        cpu_mem_wstrb = 4'd0;
        err_clr       = 1'b0;
        bram_rdata    = 32'd0;
        gpio_rdata    = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        b_at = 2; bram_rdata = 32'h1234_5678;
        do_req("bram read", 32'h0000_0010, 32'd0, 4'h0, 1'b0,
               32'h1234_5678, 1'b0, 32'd0, 3);
        chk("bram read addr", b_addr_cap, 32'h10);
        chk("bram read gpio idle", 32'(g_seen), 32'd0);

        g_at = 3; gpio_rdata = 32'h0000_00AA;
        do_req("gpio write", 32'h0200_0004, 32'hA5A5_0001, 4'hF, 1'b0,
               32'h0000_00AA, 1'b0, 32'd0, 4);
        chk("gpio write addr", g_addr_cap, 32'h4);
        chk("gpio write wdata", g_wdata_cap, 32'hA5A5_0001);
        chk("gpio write wstrb", 32'(g_wstrb_cap), 32'hF);
        chk("gpio write stable", 32'(g_unstable), 32'd0);
        chk("gpio write bram idle", 32'(b_seen), 32'd0);

        do_req("unmapped", 32'h1000_0000, 32'd0, 4'h0, 1'b0,
               32'hDEAD_BEEF, 1'b1, 32'h1000_0000, 1);
        chk("unmapped no target", 32'(b_seen | g_seen), 32'd0);
        clear_err(32'hDEAD_BEEF);

        g_at = 0;
        do_req("gpio timeout", 32'h0200_0008, 32'd0, 4'h0, 1'b0,
               32'hDEAD_BEEF, 1'b1, 32'h0200_0008, 17);
        chk("timeout valid cycles", 32'(g_cycles), 32'd16);
        clear_err(32'hDEAD_BEEF);

        g_at = 16; gpio_rdata = 32'hCAFE_0016;
        do_req("gpio last cycle", 32'h0200_0008, 32'd0, 4'h0, 1'b0,
               32'hCAFE_0016, 1'b0, 32'h0200_0008, 17);
        chk("last cycle valid cycles", 32'(g_cycles), 32'd16);

        do_req("unmapped a", 32'h3000_0000, 32'd0, 4'h0, 1'b0,
               32'hDEAD_BEEF, 1'b1, 32'h3000_0000, 1);
        do_req("err+clr", 32'h1000_0004, 32'd0, 4'h0, 1'b1,
               32'hDEAD_BEEF, 1'b1, 32'h1000_0004, 1);

        b_at = 1; bram_rdata = 32'hBEEF_0001;
        do_req("bram top", 32'h0000_FFFC, 32'h1122_3344, 4'h3, 1'b0,
               32'hBEEF_0001, 1'b1, 32'h1000_0004, 2);
        chk("bram top addr", b_addr_cap, 32'h0000_FFFC);
        do_req("bram end+1", 32'h0001_0000, 32'd0, 4'h0, 1'b0,
               32'hDEAD_BEEF, 1'b1, 32'h0001_0000, 1);

        g_at = 2; gpio_rdata = 32'h5A5A_5A5A;
        do_req("gpio top", 32'h0200_0FFC, 32'd0, 4'h0, 1'b0,
               32'h5A5A_5A5A, 1'b1, 32'h0001_0000, 3);
        chk("gpio top addr", g_addr_cap, 32'h0000_0FFC);
        do_req("gpio end+1", 32'h0200_1000, 32'd0, 4'h0, 1'b0,
               32'hDEAD_BEEF, 1'b1, 32'h0200_1000, 1);

        b_at = 3; bram_rdata = 32'h7777_8888; g_stuck = 1'b1;
        do_req("gpio ready ignored", 32'h0000_0020, 32'd0, 4'h0, 1'b0,
               32'h7777_8888, 1'b1, 32'h0200_1000, 4);
        g_stuck = 1'b0;

        b_at = 0;
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h0000_0080;
        cpu_mem_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        chk("mid access bram_valid", 32'(bram_valid), 32'd1);
        cpu_mem_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        b_at = 2; bram_rdata = 32'h0BAD_F00D;
        do_req("after reset", 32'h0000_0040, 32'd0, 4'h0, 1'b0,
               32'h0BAD_F00D, 1'b0, 32'd0, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
